uart_rx_mmio: RTL and testbench

//  UART receiver: the receive counterpart of the SoC's uart_tx path. Deserialises 8N1 frames from
//  pin uart_rx into a small FIFO. Exposes MMIO registers in the IO region for hart polling.

---
 rtl/uart_rx_mmio_if.sv | 33 +++
 rtl/uart_rx_mmio.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_mmio_if.sv
// rtl/uart_rx_mmio_if.sv - MMIO access bus between hart IO region and uart_rx_mmio
//
// Purpose: groups the single-cycle MMIO strobe bus of the UART receiver.
// Signals:
//   io_en     access strobe, one cycle per access
//   io_we     1 = write, 0 = read (valid with io_en)
//   io_addr   byte offset within the block, word aligned
//   io_wdata  write data
//   io_rdata  read data, valid the cycle after a read strobe
`timescale 1ns/1ps
interface uart_rx_mmio_if;
    logic        io_en;
    logic        io_we;
    logic [3:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output io_en,
        output io_we,
        output io_addr,
        output io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_en,
        input  io_we,
        input  io_addr,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - 8N1 UART receiver with RX FIFO, MMIO registers and level IRQ
//
// Purpose: deserialises 8N1 frames from uart_rx into a FIFO that the hart polls
// through MMIO registers; raises a level interrupt when data or errors are pending.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   uart_rx  asynchronous serial input, idle high
//   bus      MMIO slave port (io_en/io_we/io_addr/io_wdata in, io_rdata out)
//   irq      registered level interrupt request
// Registers:
//   0x0 RXDATA (R, pops)  0x4 STATUS (R)  0x8 CTRL (R/W)  0xC CLR (W)
`timescale 1ns/1ps
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_rx,
    uart_rx_mmio_if.slave   bus,
    output logic            irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] HALF_RELOAD = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_RELOAD = BW'(CLKS_PER_BIT - 1);

    localparam logic [3:0] ADDR_RXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_CLR    = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITHI
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; resets to the idle (high) line level
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], uart_rx};
    end

    assign rx_s = sync_q[1];

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            cnt_zero;

    logic            load_half, load_full, shift_en, push, ferr_set;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ne, full, pop, push_ok, ovr_set;

    logic [1:0]      ctrl_q, ctrl_d;
    logic            ovr_q, ovr_d, ferr_q, ferr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            irq_q, irq_d;

    logic            rd_access, wr_access, clr_wr;
    logic            unused_wdata;

    assign cnt_zero = (cnt_q == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ctrl_q[0] && !rx_s) state_d = S_START;
            S_START:  if (cnt_zero) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (cnt_zero && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:   if (cnt_zero) state_d = rx_s ? S_IDLE : S_WAITHI;
            S_WAITHI: if (rx_s) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (datapath controls)
    // ------------------------------------------------------------------
    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            S_IDLE:  load_half = ctrl_q[0] & ~rx_s;
            S_START: load_full = cnt_zero & ~rx_s;
            S_DATA: begin
                shift_en  = cnt_zero;
                load_full = cnt_zero;
            end
            S_STOP: begin
                push     = cnt_zero & rx_s;
                ferr_set = cnt_zero & ~rx_s;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Baud counter, bit index and shift register
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (load_half)      cnt_d = HALF_RELOAD;
        else if (load_full) cnt_d = FULL_RELOAD;
        else if (!cnt_zero) cnt_d = cnt_q - BW'(1);

        // Bit index only advances while in DATA; any other state rearms it at 0.
        bit_d = 3'd0;
        if (state_q == S_DATA) bit_d = shift_en ? bit_q + 3'd1 : bit_q;

        shreg_d = shift_en ? {rx_s, shreg_q[7:1]} : shreg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    assign rd_access = bus.io_en & ~bus.io_we;
    assign wr_access = bus.io_en &  bus.io_we;
    assign clr_wr    = wr_access & (bus.io_addr == ADDR_CLR);

    assign ne   = (count_q != '0);
    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = rd_access & (bus.io_addr == ADDR_RXDATA) & ne;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
    end

    // ------------------------------------------------------------------
    // Registers, read mux and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_access && bus.io_addr == ADDR_CTRL) ctrl_d = bus.io_wdata[1:0];

        // A new error event in the same cycle as its clear keeps the flag set.
        ovr_d  = ovr_set  | (ovr_q  & ~(clr_wr & bus.io_wdata[2]));
        ferr_d = ferr_set | (ferr_q & ~(clr_wr & bus.io_wdata[3]));

        rdata_d = 32'h0;
        if (rd_access) begin
            case (bus.io_addr)
                ADDR_RXDATA: rdata_d = {24'h0, ne ? mem_q[rd_ptr_q] : 8'h00};
                ADDR_STATUS: rdata_d = {23'h0, 5'(count_q), ferr_q, ovr_q, full, ne};
                ADDR_CTRL:   rdata_d = {30'h0, ctrl_q};
                default:     rdata_d = 32'h0;
            endcase
        end

        irq_d = ctrl_q[1] & (ne | ovr_q | ferr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= 2'b00;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            rdata_q <= 32'h0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.io_rdata = rdata_q;
    assign irq          = irq_q;

    // Write data above bit 3 has no register behind it.
    assign unused_wdata = ^bus.io_wdata[31:4];

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - directed self-checking bench for uart_rx_mmio
`timescale 1ns/1ps
module tb_uart_rx_mmio;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic uart_rx;
    logic irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;

    uart_rx_mmio_if bus ();

    uart_rx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mmio_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.io_en    = 1'b1;
        bus.io_we    = 1'b1;
        bus.io_addr  = addr;
        bus.io_wdata = data;
        @(negedge clk);
        bus.io_en    = 1'b0;
        bus.io_we    = 1'b0;
        bus.io_wdata = 32'h0;
    endtask

    task automatic mmio_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.io_en   = 1'b1;
        bus.io_we   = 1'b0;
        bus.io_addr = addr;
        @(negedge clk);
        bus.io_en   = 1'b0;
        data        = bus.io_rdata;
    endtask

    // Start bit, 8 data bits LSB first, then the stop level held for stop_len cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
        @(negedge clk);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(stop_len);
        uart_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, CPB);
    endtask

    initial begin
        rst          = 1'b1;
        uart_rx      = 1'b1;
        bus.io_en    = 1'b0;
        bus.io_we    = 1'b0;
        bus.io_addr  = 4'h0;
        bus.io_wdata = 32'h0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_rdata", bus.io_rdata, 32'h0);
        mmio_read(4'h4, rd); check("reset_status", rd, 32'h000);
        mmio_read(4'h8, rd); check("reset_ctrl", rd, 32'h0);

        // 1. single frame
        mmio_write(4'h8, 32'h1);
        mmio_read(4'h8, rd); check("ctrl_readback", rd, 32'h1);
        send_byte(8'hA5);
        tick(2);
        mmio_read(4'h4, rd); check("t1_status_one", rd, 32'h011);
        mmio_read(4'h0, rd); check("t1_rxdata", rd, 32'h0000_00A5);
        mmio_read(4'h4, rd); check("t1_status_empty", rd, 32'h000);
        mmio_read(4'h0, rd); check("t1_rxdata_empty", rd, 32'h0);
        mmio_read(4'h4, rd); check("t1_no_pop_when_empty", rd, 32'h000);

        // 2. interrupt
        mmio_write(4'h8, 32'h3);
        tick(1);
        check("t2_irq_idle", {31'h0, irq}, 32'h0);
        send_byte(8'h3C);
        check("t2_irq_set", {31'h0, irq}, 32'h1);
        mmio_read(4'h0, rd); check("t2_rxdata", rd, 32'h0000_003C);
        check("t2_irq_still_set", {31'h0, irq}, 32'h1);
        tick(1);
        check("t2_irq_clear", {31'h0, irq}, 32'h0);

        // 3. overflow
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        tick(2);
        mmio_read(4'h4, rd); check("t3_status_full_ovr", rd, 32'h047);
        check("t3_irq", {31'h0, irq}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            mmio_read(4'h0, rd);
            check($sformatf("t3_rxdata_%0d", i), rd, 32'(i));
        end
        mmio_read(4'h4, rd); check("t3_status_ovr_only", rd, 32'h004);
        mmio_write(4'hC, 32'h4);
        mmio_read(4'h4, rd); check("t3_status_cleared", rd, 32'h000);

        // 4. framing error and break hold
        send_frame(8'h55, 1'b0, 40);
        tick(4);
        mmio_read(4'h4, rd); check("t4_status_ferr", rd, 32'h008);
        check("t4_irq_ferr", {31'h0, irq}, 32'h1);
        tick(40);
        mmio_read(4'h4, rd); check("t4_no_retrigger", rd, 32'h008);
        send_byte(8'h7E);
        tick(2);
        mmio_read(4'h4, rd); check("t4_status_after", rd, 32'h019);
        mmio_read(4'h0, rd); check("t4_rxdata", rd, 32'h0000_007E);
        mmio_write(4'hC, 32'h8);
        mmio_read(4'h4, rd); check("t4_ferr_cleared", rd, 32'h000);
        mmio_read(4'hC, rd); check("t4_clr_reads_zero", rd, 32'h0);

        // 5. glitch and EN gating
        @(negedge clk);
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(30);
        mmio_read(4'h4, rd); check("t5_glitch_status", rd, 32'h000);
        mmio_write(4'h8, 32'h0);
        send_byte(8'h99);
        tick(4);
        mmio_read(4'h4, rd); check("t5_disabled_status", rd, 32'h000);

        // 6. reset mid-frame
        mmio_write(4'h8, 32'h3);
        send_byte(8'h44);
        tick(2);
        check("t6_irq_before_reset", {31'h0, irq}, 32'h1);
        @(negedge clk);
        uart_rx = 1'b0;
        tick(CPB);
        uart_rx = 1'b1;
        tick(40);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("t6_irq_after_reset", {31'h0, irq}, 32'h0);
        mmio_read(4'h4, rd); check("t6_status_after_reset", rd, 32'h000);
        mmio_read(4'h8, rd); check("t6_ctrl_after_reset", rd, 32'h0);
        tick(120);
        mmio_write(4'h8, 32'h1);
        send_byte(8'h81);
        tick(2);
        mmio_read(4'h4, rd); check("t6_status_next", rd, 32'h011);
        mmio_read(4'h0, rd); check("t6_rxdata_next", rd, 32'h0000_0081);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
